// File: rtl/encoder_gate_scheduler_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : encoder_pkg
// Brief    : Shared enums, defaults and width helper for the encoder blocks.
// Revision : 1.0 - initial release
// ============================================================================
package encoder_pkg;

    localparam int GATE_LEN_DEFAULT = 29;
    localparam int CW_DEFAULT       = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GATE = 1'b1
    } gate_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_SEND = 1'b1
    } rd_state_t;

    // Channel-index width; never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/encoder_gate_scheduler_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : encoder_gate_scheduler_if
// Brief    : Control, encoder-input and valid/ready readout bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface encoder_gate_scheduler_if
    import encoder_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = CW_DEFAULT,
    parameter int GW  = 8
);
    localparam int CH_W = ch_w(NCH);

    logic            ENABLE;
    logic [GW-1:0]   GATE_LEN;
    logic [NCH-1:0]  A;
    logic [CW-1:0]   DATA;
    logic [CH_W-1:0] CH;
    logic            SAT;
    logic            VALID;
    logic            READY;
    logic            FRAME_DONE;
    logic            OVERRUN;
    logic            OVR_CLR;

    modport slave (
        input  ENABLE, GATE_LEN, A, READY, OVR_CLR,
        output DATA, CH, SAT, VALID, FRAME_DONE, OVERRUN
    );

    modport master (
        output ENABLE, GATE_LEN, A, READY, OVR_CLR,
        input  DATA, CH, SAT, VALID, FRAME_DONE, OVERRUN
    );
endinterface
`default_nettype wire

// File: rtl/encoder_gate_scheduler_chan_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : encoder_chan_counter
// Brief    : Per-channel synchronizer, rising-edge detect, saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module encoder_chan_counter
    import encoder_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  wire logic          OUT_CLK,
    input  wire logic          RST,
    input  wire logic          i_a,
    input  wire logic          i_clear,
    input  wire logic          i_reload,
    output logic [CW-1:0]      o_count,
    output logic               o_sat
);
    localparam logic [CW-1:0] c_max = '1;

    logic          r_s1, r_s2, r_s3;
    logic [CW-1:0] r_cnt;
    logic          r_sat;
    logic          w_edge;

    assign w_edge  = r_s2 & ~r_s3;
    assign o_count = r_cnt;
    assign o_sat   = r_sat;

    always_ff @(posedge OUT_CLK or posedge RST) begin
        if (RST) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_s3  <= 1'b0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else begin
            r_s1 <= i_a;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (i_clear) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (i_reload) begin
                // An edge in the window-end cycle opens the next window.
                r_cnt <= CW'(w_edge);
                r_sat <= 1'b0;
            end else if (w_edge) begin
                if (r_cnt == c_max) begin
                    r_sat <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/encoder_gate_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : encoder_gate_scheduler
// Brief    : Shared gate-window sequencer with snapshot/shadow serial readout.
// Revision : 1.0 - initial release
// ============================================================================
module encoder_gate_scheduler
    import encoder_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = CW_DEFAULT,
    parameter int GW  = 8
) (
    input  wire logic                 OUT_CLK,
    input  wire logic                 RST,
    encoder_gate_scheduler_if.slave   bus
);
    localparam int              CH_W      = ch_w(NCH);
    localparam logic [CH_W-1:0] c_last_ch = CH_W'(NCH - 1);

    gate_state_t     r_gate_state, w_gate_next;
    rd_state_t       r_rd_state, w_rd_next;
    logic [GW-1:0]   r_tick, r_len_q;
    logic            w_win_end, w_cnt_clear;
    logic            w_last, w_load, w_adv, w_ovr_set;
    logic [CW-1:0]   w_cnt [NCH];
    logic [NCH-1:0]  w_sat;
    logic [CW-1:0]   r_shadow [NCH];
    logic [NCH-1:0]  r_shadow_sat;
    logic [CH_W-1:0] r_ch, w_ch_nxt;
    logic [CW-1:0]   r_data;
    logic            r_sat_out;
    logic            r_overrun;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        encoder_chan_counter #(.CW(CW)) u_cnt (
            .OUT_CLK  (OUT_CLK),
            .RST      (RST),
            .i_a      (bus.A[gi]),
            .i_clear  (w_cnt_clear),
            .i_reload (w_win_end),
            .o_count  (w_cnt[gi]),
            .o_sat    (w_sat[gi])
        );
    end

    always_ff @(posedge OUT_CLK or posedge RST) begin
        if (RST) begin
            r_gate_state <= IDLE;
            r_rd_state   <= RD_IDLE;
        end else begin
            r_gate_state <= w_gate_next;
            r_rd_state   <= w_rd_next;
        end
    end

    // Dropping ENABLE takes priority over a coincident window end.
    always_comb begin
        w_gate_next = r_gate_state;
        w_win_end   = 1'b0;
        w_cnt_clear = 1'b0;
        case (r_gate_state)
            IDLE: begin
                w_cnt_clear = 1'b1;
                if (bus.ENABLE) w_gate_next = GATE;
            end
            GATE: begin
                if (!bus.ENABLE) begin
                    w_gate_next = IDLE;
                    w_cnt_clear = 1'b1;
                end else if (r_tick == r_len_q) begin
                    w_win_end = 1'b1;
                end
            end
            default: w_gate_next = IDLE;
        endcase
    end

    always_comb begin
        w_rd_next = r_rd_state;
        w_last    = 1'b0;
        w_load    = 1'b0;
        w_adv     = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if (w_win_end) begin
                    w_load    = 1'b1;
                    w_rd_next = RD_SEND;
                end
            end
            RD_SEND: begin
                w_last = bus.READY && (r_ch == c_last_ch);
                if (w_last) begin
                    w_load    = w_win_end;
                    w_rd_next = w_win_end ? RD_SEND : RD_IDLE;
                end else if (bus.READY) begin
                    w_adv = 1'b1;
                end
            end
            default: w_rd_next = RD_IDLE;
        endcase
    end

    assign w_ovr_set = w_win_end && (r_rd_state == RD_SEND) && !w_last;
    assign w_ch_nxt  = r_ch + 1'b1;

    always_ff @(posedge OUT_CLK or posedge RST) begin
        if (RST) begin
            r_tick  <= '0;
            r_len_q <= '0;
        end else if (w_cnt_clear) begin
            r_tick <= '0;
            if (bus.ENABLE) r_len_q <= bus.GATE_LEN;
        end else if (w_win_end) begin
            r_tick  <= '0;
            r_len_q <= bus.GATE_LEN;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    always_ff @(posedge OUT_CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NCH; i++) r_shadow[i] <= '0;
            r_shadow_sat <= '0;
            r_ch         <= '0;
            r_data       <= '0;
            r_sat_out    <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_load) begin
                for (int i = 0; i < NCH; i++) r_shadow[i] <= w_cnt[i];
                r_shadow_sat <= w_sat;
                r_ch         <= '0;
                r_data       <= w_cnt[0];
                r_sat_out    <= w_sat[0];
            end else if (w_adv) begin
                r_ch      <= w_ch_nxt;
                r_data    <= r_shadow[w_ch_nxt];
                r_sat_out <= r_shadow_sat[w_ch_nxt];
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (bus.OVR_CLR) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.DATA       = r_data;
    assign bus.CH         = r_ch;
    assign bus.SAT        = r_sat_out;
    assign bus.VALID      = (r_rd_state == RD_SEND);
    assign bus.FRAME_DONE = w_last;
    assign bus.OVERRUN    = r_overrun;
endmodule
`default_nettype wire
